apb_cfg_initiator: RTL and testbench



---
 rtl/apb_cfg_initiator_pkg.sv | 33 +++
 rtl/apb_cfg_initiator_if.sv | 30 +++
 rtl/apb_cfg_timeout.sv | 47 ++++
 rtl/apb_cfg_initiator.sv | 154 +++++++++++++++
 tb/tb_apb_cfg_initiator.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_cfg_initiator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_cfg_pkg
// Description : Shared types and constants for the APB configuration
//               initiator: FSM state encoding, timeout read-data marker and
//               the request bundle layout.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_cfg_pkg;

   // Initiator state machine; one transfer outstanding at a time.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_init_state_e;

   // Read data returned when a transfer is aborted by the watchdog.
   localparam logic [31:0] APB_TIMEOUT_RDATA = 32'hDEADBEEF;

   // Widest supported APB address; narrower buses use the low bits.
   localparam int unsigned APB_CFG_ADDR_MAX = 32;

   // Command as presented by the upstream source.
   typedef struct packed {
      logic                        write;
      logic [APB_CFG_ADDR_MAX-1:0] addr;
      logic [31:0]                 wdata;
   } apb_cfg_req_t;

endpackage : apb_cfg_pkg
`default_nettype wire

// File: rtl/apb_cfg_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_cfg_initiator_if
// Description : APB3 bus bundle between the configuration initiator
//               (master modport) and a peripheral slave (slave modport).
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_cfg_initiator_if #(
   parameter int unsigned ADDR_W = 12
) ();
   logic [ADDR_W-1:0] PADDR;
   logic [31:0]       PWDATA;
   logic              PWRITE;
   logic              PSEL;
   logic              PENABLE;
   logic [31:0]       PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
      output PRDATA, PREADY, PSLVERR
   );
endinterface : apb_cfg_initiator_if
`default_nettype wire

// File: rtl/apb_cfg_timeout.sv
`default_nettype none
// ============================================================================
// Module      : apb_cfg_timeout
// Description : 16-bit ACCESS-phase watchdog. Cleared on entry to ACCESS,
//               counts wait cycles, flags expiry on the cycle whose wait
//               would make the count reach TIMEOUT_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_cfg_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic HCLK,
   input  logic HRESETn,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   localparam logic [15:0] c_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   // Next count: clear wins over increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // Count register.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Expiry fires during the wait cycle that completes the budget.
   assign expire_o = enable_i && (cnt_q == c_LAST);

endmodule : apb_cfg_timeout
`default_nettype wire

// File: rtl/apb_cfg_initiator.sv
`default_nettype none
// ============================================================================
// Module      : apb_cfg_initiator
// Description : Converts a valid/ready command stream into APB3 transfers
//               and returns read data / error through a single-entry
//               response buffer. All outputs are registered.
//               Optional watchdog: define APB_INITIATOR_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_cfg_initiator
   import apb_cfg_pkg::*;
#(
   parameter int unsigned APB_ADDR_WIDTH = 12,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic                      req_write_i,
   input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
   input  logic [31:0]               req_wdata_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [31:0]               rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic                      rsp_timeout_o,
   apb_cfg_initiator_if.master       apb
);

   if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_timeout_range_chk
      $error("apb_cfg_initiator: TIMEOUT_CYCLES must be in 1..65535");
   end

   apb_init_state_e           state_q;
   logic [APB_ADDR_WIDTH-1:0] paddr_q;
   logic [31:0]               pwdata_q;
   logic                      pwrite_q;
   logic                      psel_q;
   logic                      penable_q;
   logic                      req_ready_q;
   logic                      rsp_valid_q;
   logic [31:0]               rsp_rdata_q;
   logic                      rsp_err_q;
   logic                      w_accept;

   assign w_accept = req_valid_i && req_ready_q;

`ifdef APB_INITIATOR_TIMEOUT_EN
   logic w_expire;
   logic rsp_timeout_q;

   apb_cfg_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .clear_i  (state_q == SETUP),
      .enable_i ((state_q == ACCESS) && !apb.PREADY),
      .expire_o (w_expire)
   );
`endif

   // Transfer sequencing; every bus and response output is a flop here.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q       <= IDLE;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         pwrite_q      <= 1'b0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         req_ready_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
`ifdef APB_INITIATOR_TIMEOUT_EN
         rsp_timeout_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               req_ready_q <= 1'b1;
               if (w_accept) begin
                  paddr_q     <= req_addr_i;
                  pwdata_q    <= req_wdata_i;
                  pwrite_q    <= req_write_i;
                  psel_q      <= 1'b1;
                  penable_q   <= 1'b0;
                  req_ready_q <= 1'b0;
                  state_q     <= SETUP;
               end
            end
            SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ACCESS;
            end
            ACCESS: begin
               // A ready slave beats the watchdog on the expiry cycle.
               if (apb.PREADY) begin
                  psel_q        <= 1'b0;
                  penable_q     <= 1'b0;
                  rsp_rdata_q   <= pwrite_q ? 32'd0 : apb.PRDATA;
                  rsp_err_q     <= apb.PSLVERR;
`ifdef APB_INITIATOR_TIMEOUT_EN
                  rsp_timeout_q <= 1'b0;
`endif
                  rsp_valid_q   <= 1'b1;
                  state_q       <= RESP;
               end
`ifdef APB_INITIATOR_TIMEOUT_EN
               else if (w_expire) begin
                  psel_q        <= 1'b0;
                  penable_q     <= 1'b0;
                  rsp_rdata_q   <= APB_TIMEOUT_RDATA;
                  rsp_err_q     <= 1'b1;
                  rsp_timeout_q <= 1'b1;
                  rsp_valid_q   <= 1'b1;
                  state_q       <= RESP;
               end
`endif
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign req_ready_o = req_ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;
`ifdef APB_INITIATOR_TIMEOUT_EN
   assign rsp_timeout_o = rsp_timeout_q;
`else
   assign rsp_timeout_o = 1'b0;
`endif

   assign apb.PADDR   = paddr_q;
   assign apb.PWDATA  = pwdata_q;
   assign apb.PWRITE  = pwrite_q;
   assign apb.PSEL    = psel_q;
   assign apb.PENABLE = penable_q;

endmodule : apb_cfg_initiator
`default_nettype wire

// File: tb/tb_apb_cfg_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_cfg_initiator
// Description : Directed self-checking bench for apb_cfg_initiator.
//               Watchdog scenarios run when APB_INITIATOR_TIMEOUT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_cfg_initiator;

   logic        HCLK;
   logic        HRESETn;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_write_i;
   logic [11:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        rsp_timeout_o;

   int n_pass  = 0;
   int n_total = 0;

   apb_cfg_initiator_if #(.ADDR_W(12)) apb_bus ();

   apb_cfg_initiator #(
      .APB_ADDR_WIDTH (12),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .HCLK          (HCLK),
      .HRESETn       (HRESETn),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_write_i   (req_write_i),
      .req_addr_i    (req_addr_i),
      .req_wdata_i   (req_wdata_i),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_ready_i   (rsp_ready_i),
      .rsp_rdata_o   (rsp_rdata_o),
      .rsp_err_o     (rsp_err_o),
      .rsp_timeout_o (rsp_timeout_o),
      .apb           (apb_bus.master)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic send(input logic wr, input logic [11:0] addr, input logic [31:0] wd);
      req_valid_i = 1'b1;
      req_write_i = wr;
      req_addr_i  = addr;
      req_wdata_i = wd;
   endtask

   initial begin
      HRESETn           = 1'b0;
      req_valid_i       = 1'b0;
      req_write_i       = 1'b0;
      req_addr_i        = '0;
      req_wdata_i       = '0;
      rsp_ready_i       = 1'b0;
      apb_bus.PRDATA    = '0;
      apb_bus.PREADY    = 1'b0;
      apb_bus.PSLVERR   = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_psel",    {31'd0, apb_bus.PSEL},    32'd0);
      check("rst_penable", {31'd0, apb_bus.PENABLE}, 32'd0);
      check("rst_pwrite",  {31'd0, apb_bus.PWRITE},  32'd0);
      check("rst_paddr",   {20'd0, apb_bus.PADDR},   32'd0);
      check("rst_pwdata",  apb_bus.PWDATA,           32'd0);
      check("rst_req_rdy", {31'd0, req_ready_o},     32'd0);
      check("rst_rsp_vld", {31'd0, rsp_valid_o},     32'd0);
      check("rst_rsp_err", {31'd0, rsp_err_o},       32'd0);
      check("rst_rsp_to",  {31'd0, rsp_timeout_o},   32'd0);
      check("rst_rdata",   rsp_rdata_o,              32'd0);
      HRESETn = 1'b1;
      tick();
      check("post_rst_req_rdy", {31'd0, req_ready_o}, 32'd1);

      // Write, zero-wait slave
      send(1'b1, 12'h004, 32'h1A000100);
      apb_bus.PREADY = 1'b1;
      apb_bus.PRDATA = 32'hFFFFFFFF;
      tick();                                   // T0 accept
      req_valid_i = 1'b0;
      check("wr_setup_psel",    {31'd0, apb_bus.PSEL},    32'd1);
      check("wr_setup_penable", {31'd0, apb_bus.PENABLE}, 32'd0);
      check("wr_paddr",         {20'd0, apb_bus.PADDR},   32'h004);
      check("wr_pwdata",        apb_bus.PWDATA,           32'h1A000100);
      check("wr_pwrite",        {31'd0, apb_bus.PWRITE},  32'd1);
      check("wr_req_rdy_busy",  {31'd0, req_ready_o},     32'd0);
      tick();                                   // T1 ACCESS
      check("wr_access_psel",    {31'd0, apb_bus.PSEL},    32'd1);
      check("wr_access_penable", {31'd0, apb_bus.PENABLE}, 32'd1);
      check("wr_no_rsp_yet",     {31'd0, rsp_valid_o},     32'd0);
      tick();                                   // T2 response
      check("wr_psel_drop", {31'd0, apb_bus.PSEL}, 32'd0);
      check("wr_rsp_vld",   {31'd0, rsp_valid_o},  32'd1);
      check("wr_rsp_err",   {31'd0, rsp_err_o},    32'd0);
      check("wr_rsp_rdata", rsp_rdata_o,           32'd0);
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      check("wr_rsp_done", {31'd0, rsp_valid_o}, 32'd0);
      check("wr_req_rdy",  {31'd0, req_ready_o}, 32'd1);

      // Read with three wait states
      apb_bus.PREADY = 1'b0;
      apb_bus.PRDATA = 32'h12345678;
      send(1'b0, 12'h0F8, 32'h0);
      tick();
      req_valid_i = 1'b0;
      tick();                                   // ACCESS cycle 1
      for (int i = 0; i < 4; i++) begin
         check("rd_wait_penable", {31'd0, apb_bus.PENABLE}, 32'd1);
         check("rd_wait_paddr",   {20'd0, apb_bus.PADDR},   32'h0F8);
         check("rd_wait_no_rsp",  {31'd0, rsp_valid_o},     32'd0);
         if (i == 3) begin
            apb_bus.PREADY = 1'b1;
            apb_bus.PRDATA = 32'h000000A5;
         end
         tick();
      end
      check("rd_rsp_vld",   {31'd0, rsp_valid_o},     32'd1);
      check("rd_rsp_rdata", rsp_rdata_o,              32'h000000A5);
      check("rd_rsp_err",   {31'd0, rsp_err_o},       32'd0);
      check("rd_psel_drop", {31'd0, apb_bus.PSEL},    32'd0);
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;

      // Read with slave error
      apb_bus.PSLVERR = 1'b1;
      apb_bus.PRDATA  = 32'hDEADBEEF;
      send(1'b0, 12'h3FC, 32'h0);
      tick();
      req_valid_i = 1'b0;
      tick();
      tick();
      check("err_rsp_vld",   {31'd0, rsp_valid_o},   32'd1);
      check("err_rsp_err",   {31'd0, rsp_err_o},     32'd1);
      check("err_rsp_to",    {31'd0, rsp_timeout_o}, 32'd0);
      check("err_rsp_rdata", rsp_rdata_o,            32'hDEADBEEF);
      apb_bus.PSLVERR = 1'b0;
      apb_bus.PRDATA  = 32'h0;

      // Backpressure on the response while a second request waits
      send(1'b1, 12'h010, 32'h00000055);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_req_rdy", {31'd0, req_ready_o}, 32'd0);
         check("bp_rsp_vld", {31'd0, rsp_valid_o}, 32'd1);
         check("bp_rdata",   rsp_rdata_o,          32'hDEADBEEF);
         check("bp_err",     {31'd0, rsp_err_o},   32'd1);
         check("bp_psel",    {31'd0, apb_bus.PSEL}, 32'd0);
      end
      rsp_ready_i = 1'b1;
      tick();                                   // response handshake
      rsp_ready_i = 1'b0;
      check("bp_rsp_gone",   {31'd0, rsp_valid_o},  32'd0);
      check("bp_req_rdy_up", {31'd0, req_ready_o},  32'd1);
      check("bp_not_yet",    {31'd0, apb_bus.PSEL}, 32'd0);
      tick();                                   // second request accepted
      req_valid_i = 1'b0;
      check("bp2_psel",   {31'd0, apb_bus.PSEL},   32'd1);
      check("bp2_paddr",  {20'd0, apb_bus.PADDR},  32'h010);
      check("bp2_pwdata", apb_bus.PWDATA,          32'h00000055);
      tick();
      tick();
      check("bp2_rsp_vld", {31'd0, rsp_valid_o}, 32'd1);
      check("bp2_rsp_err", {31'd0, rsp_err_o},   32'd0);
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;

`ifdef APB_INITIATOR_TIMEOUT_EN
      // Slave never ready: abort after 8 ACCESS cycles
      apb_bus.PREADY = 1'b0;
      send(1'b0, 12'h020, 32'h0);
      tick();
      req_valid_i = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         check("to_psel_held", {31'd0, apb_bus.PSEL}, 32'd1);
         check("to_no_rsp",    {31'd0, rsp_valid_o},  32'd0);
         tick();
      end
      check("to_psel_drop", {31'd0, apb_bus.PSEL},   32'd0);
      check("to_rsp_vld",   {31'd0, rsp_valid_o},    32'd1);
      check("to_rsp_err",   {31'd0, rsp_err_o},      32'd1);
      check("to_rsp_to",    {31'd0, rsp_timeout_o},  32'd1);
      check("to_rsp_rdata", rsp_rdata_o,             32'hDEADBEEF);
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;

      // PREADY on the expiry cycle completes normally
      send(1'b0, 12'h024, 32'h0);
      tick();
      req_valid_i = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         check("tor_psel_held", {31'd0, apb_bus.PSEL}, 32'd1);
         if (i == 7) begin
            apb_bus.PREADY = 1'b1;
            apb_bus.PRDATA = 32'h00000011;
         end
         tick();
      end
      check("tor_rsp_vld",   {31'd0, rsp_valid_o},   32'd1);
      check("tor_rsp_err",   {31'd0, rsp_err_o},     32'd0);
      check("tor_rsp_to",    {31'd0, rsp_timeout_o}, 32'd0);
      check("tor_rsp_rdata", rsp_rdata_o,            32'h00000011);
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
`endif

      // Asynchronous reset during ACCESS
      apb_bus.PREADY = 1'b0;
      send(1'b0, 12'h030, 32'h0);
      tick();
      req_valid_i = 1'b0;
      tick();
      check("ar_access_psel",    {31'd0, apb_bus.PSEL},    32'd1);
      check("ar_access_penable", {31'd0, apb_bus.PENABLE}, 32'd1);
      #2;
      HRESETn = 1'b0;
      #1;
      check("ar_psel_now",    {31'd0, apb_bus.PSEL},    32'd0);
      check("ar_penable_now", {31'd0, apb_bus.PENABLE}, 32'd0);
      apb_bus.PREADY = 1'b1;
      tick();
      HRESETn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("ar_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
      end
      check("ar_req_rdy", {31'd0, req_ready_o}, 32'd1);
      send(1'b1, 12'h008, 32'hCAFE0001);
      tick();
      req_valid_i = 1'b0;
      check("ar2_paddr", {20'd0, apb_bus.PADDR}, 32'h008);
      tick();
      tick();
      check("ar2_rsp_vld", {31'd0, rsp_valid_o}, 32'd1);
      check("ar2_rsp_err", {31'd0, rsp_err_o},   32'd0);
      check("ar2_rdata",   rsp_rdata_o,          32'd0);
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      check("ar2_done", {31'd0, rsp_valid_o}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_apb_cfg_initiator
`default_nettype wire
